// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and line levels.
// Also intended for use by the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_fifo_tx_if.sv
// Read port of a show-ahead FIFO: head word valid whenever !empty, pop on read_enable.
// master = the consumer issuing pops, slave = the FIFO itself.
interface uart_fifo_tx_if #(
  parameter int data_bits = 8
);

  logic                 empty;
  logic [data_bits-1:0] read_data;
  logic                 read_enable;

  modport master (input empty, input read_data, output read_enable);
  modport slave  (output empty, output read_data, input read_enable);

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..clocks_per_bit-1 while run is high, tick on the last count.
// Shared between the UART transmitter and receiver.
module uart_bit_timer #(
  parameter int clocks_per_bit = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int                CNT_W    = $clog2(clocks_per_bit);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(clocks_per_bit - 1);

  logic [CNT_W-1:0] count;

  assign tick = run && (count == LAST_CNT);

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || !run || tick) count <= '0;
    else                       count <= count + 1'b1;
  end

endmodule

// File: rtl/uart_fifo_tx.sv
// Pops bytes from a show-ahead FIFO and sends them LSB first as UART frames on tx.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by odd_parity) after the data bits.
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int clocks_per_bit = 868,
  parameter int data_bits      = 8,
  parameter int stop_bits      = 1,
  parameter int odd_parity     = 0
) (
  input  logic           clk,
  input  logic           reset,
  uart_fifo_tx_if.master fifo,
  output logic           tx,
  output logic           busy
);

  localparam int               IDX_W     = $clog2(data_bits);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(data_bits - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(stop_bits - 1);

  if (clocks_per_bit < 2) begin : g_bad_clocks_per_bit
    $error("uart_fifo_tx: clocks_per_bit must be >= 2");
  end
  if (data_bits < 5 || data_bits > 8) begin : g_bad_data_bits
    $error("uart_fifo_tx: data_bits must be 5..8");
  end
  if (stop_bits < 1 || stop_bits > 2) begin : g_bad_stop_bits
    $error("uart_fifo_tx: stop_bits must be 1 or 2");
  end
  if (odd_parity < 0 || odd_parity > 1) begin : g_bad_odd_parity
    $error("uart_fifo_tx: odd_parity must be 0 or 1");
  end

  tx_state_t            state;
  logic [IDX_W-1:0]     bit_idx;
  logic [data_bits-1:0] shift;
  logic                 tick;
  logic                 last_stop;
  logic                 pop;
  logic                 advance_shift;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  uart_bit_timer #(
    .clocks_per_bit(clocks_per_bit)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .run  (state != IDLE),
    .tick (tick)
  );

  // Popping in the final stop cycle chains frames with no idle gap.
  assign last_stop        = (state == STOP) && tick && (bit_idx == LAST_STOP);
  assign pop              = ((state == IDLE) || last_stop) && !fifo.empty && !reset;
  assign fifo.read_enable = pop;
  assign advance_shift    = tick && ((state == START) || ((state == DATA) && (bit_idx != LAST_DATA)));

  // NOTE: the shift register is pure datapath, reloaded on every pop, so it carries no reset.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift <= fifo.read_data;
`ifdef UART_TX_PARITY_EN
      parity_bit <= (^fifo.read_data) ^ (odd_parity != 0);
`endif
    end else if (advance_shift) begin
      shift <= shift >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_idx <= '0;
      tx      <= UART_IDLE_LEVEL;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          state <= START;
          tx    <= ~UART_IDLE_LEVEL;
          busy  <= 1'b1;
        end
        START: if (tick) begin
          state   <= DATA;
          bit_idx <= '0;
          tx      <= shift[0];
        end
        DATA: if (tick) begin
          if (bit_idx == LAST_DATA) begin
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            state   <= PARITY;
            tx      <= parity_bit;
`else
            state   <= STOP;
            tx      <= UART_IDLE_LEVEL;
`endif
          end else begin
            bit_idx <= bit_idx + 1'b1;
            tx      <= shift[0];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (tick) begin
          state   <= STOP;
          bit_idx <= '0;
          tx      <= UART_IDLE_LEVEL;
        end
`endif
        STOP: if (tick) begin
          if (bit_idx != LAST_STOP) begin
            bit_idx <= bit_idx + 1'b1;
          end else if (pop) begin
            state   <= START;
            bit_idx <= '0;
            tx      <= ~UART_IDLE_LEVEL;
          end else begin
            state   <= IDLE;
            bit_idx <= '0;
            busy    <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          bit_idx <= '0;
          tx      <= UART_IDLE_LEVEL;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
